// File: rtl/resp_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : resp_sched
// Description : Round-robin packet scheduler that drains perm response FIFOs
//               onto a single 9-bit NOC link, one whole packet at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_sched #(
    parameter int NPORT   = 4,
    parameter int WR_BODY = 4,
    parameter int MG_BODY = 5,
    parameter int RD_FIX  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORT-1:0]     fifo_empty,
    input  logic [9*NPORT-1:0]   fifo_dout,
    output logic [NPORT-1:0]     fifo_rd,
    output logic                 out_valid,
    output logic                 out_ctl,
    output logic [7:0]           out_data,
    output logic [NPORT-1:0]     grant,
    output logic                 pkt_done,
    output logic                 hdr_err
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    localparam logic [2:0] c_op_rd = 3'b011;
    localparam logic [2:0] c_op_wr = 3'b100;
    localparam logic [2:0] c_op_mg = 3'b101;

    localparam logic [8:0]    c_wr_len  = 9'(WR_BODY);
    localparam logic [8:0]    c_mg_len  = 9'(MG_BODY);
    localparam logic [8:0]    c_rd_len  = 9'(RD_FIX);
    localparam logic [PW-1:0] c_last_rst = PW'(NPORT - 1);

    // Registered state
    logic [0:0]       state_q,     state_d;
    logic [8:0]       rem_q,       rem_d;
    logic [PW-1:0]    gidx_q,      gidx_d;
    logic [NPORT-1:0] grant_q,     grant_d;
    logic [PW-1:0]    last_q,      last_d;
    logic             rd_fix_q,    rd_fix_d;
    logic             out_valid_q, out_valid_d;
    logic             out_ctl_q,   out_ctl_d;
    logic [7:0]       out_data_q,  out_data_d;
    logic             pkt_done_q,  pkt_done_d;
    logic             hdr_err_q,   hdr_err_d;

    // Combinational helpers
    logic [8:0]       w_word [NPORT];
    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_sel;
    int               w_idx;
    logic [8:0]       w_head;
    logic             w_hdr_ok;
    logic [8:0]       w_load;
    logic [8:0]       w_gword;
    logic             w_pop;
    logic [PW-1:0]    w_pop_idx;
    logic [8:0]       w_pop_word;
    logic             w_fwd;
    logic             w_final;

    // Split the packed head-word bus into per-port words
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_word
        assign w_word[gi] = fifo_dout[9*gi +: 9];
    end

    // Round-robin search starting one past the last served (or dropped) port
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        w_sel   = '0;
        for (int k = 0; k < NPORT; k++) begin
            w_idx = (int'(last_q) + 1 + k) % NPORT;
            w_sel = PW'(w_idx);
            if (!w_found && !fifo_empty[w_sel]) begin
                w_found = 1'b1;
                w_win   = w_sel;
            end
        end
    end

    // Header decode of the arbitration winner's head word
    always_comb begin
        w_head   = w_word[w_win];
        w_hdr_ok = 1'b0;
        w_load   = '0;
        if (w_head[8] && (w_head[7:0] != 8'd0)) begin
            case (w_head[2:0])
                c_op_rd: begin w_hdr_ok = 1'b1; w_load = c_rd_len; end
                c_op_wr: begin w_hdr_ok = 1'b1; w_load = c_wr_len; end
                c_op_mg: begin w_hdr_ok = 1'b1; w_load = c_mg_len; end
                default: begin w_hdr_ok = 1'b0; w_load = '0;       end
            endcase
        end
    end

    // Next-state logic: arbitration in IDLE, word-by-word draining in XFER
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        last_d    = last_q;
        rd_fix_d  = rd_fix_q;
        hdr_err_d = hdr_err_q;
        w_pop     = 1'b0;
        w_pop_idx = gidx_q;
        w_fwd     = 1'b0;
        w_final   = 1'b0;
        w_gword   = w_word[gidx_q];

        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    w_pop     = 1'b1;
                    w_pop_idx = w_win;
                    if (w_hdr_ok) begin
                        w_fwd    = 1'b1;
                        gidx_d   = w_win;
                        rem_d    = w_load;
                        rd_fix_d = (w_head[2:0] == c_op_rd);
                        if (w_load == 9'd0) begin
                            // Header-only packet: done on the header itself
                            w_final = 1'b1;
                            last_d  = w_win;
                        end else begin
                            state_d = S_XFER;
                            grant_d = NPORT'(1) << w_win;
                        end
                    end else begin
                        // Garbage at the head: discard it and move past the port
                        hdr_err_d = 1'b1;
                        last_d    = w_win;
                    end
                end
            end
            S_XFER: begin
                // An empty granted FIFO simply stalls; nothing else is served
                if (!fifo_empty[gidx_q]) begin
                    w_pop = 1'b1;
                    w_fwd = 1'b1;
                    if (rd_fix_q && (rem_q == 9'd1)) begin
                        // Last fixed RD byte carries the data length
                        rd_fix_d = 1'b0;
                        rem_d    = {1'b0, w_gword[7:0]};
                        w_final  = (w_gword[7:0] == 8'd0);
                    end else begin
                        rem_d   = rem_q - 9'd1;
                        w_final = (rem_q == 9'd1);
                    end
                    if (w_final) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        last_d  = gidx_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output word staging: forwarded words appear one cycle after their pop
    always_comb begin
        w_pop_word  = w_word[w_pop_idx];
        out_valid_d = w_fwd;
        out_ctl_d   = w_fwd ? w_pop_word[8]   : 1'b1;
        out_data_d  = w_fwd ? w_pop_word[7:0] : 8'd0;
        pkt_done_d  = w_final;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            last_q      <= c_last_rst;
            rd_fix_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_ctl_q   <= 1'b1;
            out_data_q  <= 8'd0;
            pkt_done_q  <= 1'b0;
            hdr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            rd_fix_q    <= rd_fix_d;
            out_valid_q <= out_valid_d;
            out_ctl_q   <= out_ctl_d;
            out_data_q  <= out_data_d;
            pkt_done_q  <= pkt_done_d;
            hdr_err_q   <= hdr_err_d;
        end
    end

    // Pops are suppressed while reset is held so nothing is lost from the FIFOs
    assign fifo_rd   = (w_pop && !reset) ? (NPORT'(1) << w_pop_idx) : '0;
    assign out_valid = out_valid_q;
    assign out_ctl   = out_ctl_q;
    assign out_data  = out_data_q;
    assign grant     = grant_q;
    assign pkt_done  = pkt_done_q;
    assign hdr_err   = hdr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_resp_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_resp_sched
// Description : Scoreboard bench for resp_sched with bench-modelled FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_sched;

    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   fifo_empty;
    logic [9*NP-1:0] fifo_dout;
    logic [NP-1:0]   fifo_rd;
    logic            out_valid;
    logic            out_ctl;
    logic [7:0]      out_data;
    logic [NP-1:0]   grant;
    logic            pkt_done;
    logic            hdr_err;

    logic [8:0] fq [NP][$];
    logic [9:0] exp_q [$];
    int tests  = 0;
    int failed = 0;

    resp_sched #(.NPORT(NP), .WR_BODY(4), .MG_BODY(5), .RD_FIX(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .out_valid  (out_valid),
        .out_ctl    (out_ctl),
        .out_data   (out_data),
        .grant      (grant),
        .pkt_done   (pkt_done),
        .hdr_err    (hdr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Present FIFO heads as first-word-fall-through outputs
    task automatic refresh();
        for (int i = 0; i < NP; i++) begin
            fifo_empty[i]      = (fq[i].size() == 0);
            fifo_dout[9*i +: 9] = (fq[i].size() == 0) ? 9'h000 : fq[i][0];
        end
    endtask

    // One clock: sample pop strobes at the edge, apply them, land on negedge
    task automatic tick();
        logic [NP-1:0] rd;
        @(posedge clk);
        rd = fifo_rd;
        if (rd != '0) begin
            check("rd_onehot", {31'd0, $onehot(rd)}, 32'd1);
            for (int i = 0; i < NP; i++)
                if (rd[i]) check("rd_while_empty", {31'd0, fifo_empty[i]}, 32'd0);
        end
        #1;
        for (int i = 0; i < NP; i++)
            if (rd[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        refresh();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            #1;
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    // Header plus n body bytes base, base+1, ...
    task automatic body_pkt(input int p, input logic [8:0] hdr, input int n,
                            input logic [7:0] base, input bit ex);
        logic [8:0] w;
        fq[p].push_back(hdr);
        if (ex) exp_q.push_back({(n == 0), hdr});
        for (int k = 0; k < n; k++) begin
            w = {1'b0, base + 8'(k)};
            fq[p].push_back(w);
            if (ex) exp_q.push_back({(k == n - 1), w});
        end
    endtask

    // RD_RSP: header, two fixed bytes, length L, then L data bytes
    task automatic rd_pkt(input int p, input logic [7:0] f0, input logic [7:0] f1,
                          input logic [7:0] len, input logic [7:0] base, input bit ex);
        logic [8:0] w;
        fq[p].push_back(9'h103);
        fq[p].push_back({1'b0, f0});
        fq[p].push_back({1'b0, f1});
        fq[p].push_back({1'b0, len});
        if (ex) begin
            exp_q.push_back({1'b0, 9'h103});
            exp_q.push_back({1'b0, 1'b0, f0});
            exp_q.push_back({1'b0, 1'b0, f1});
            exp_q.push_back({(len == 8'd0), 1'b0, len});
        end
        for (int k = 0; k < int'(len); k++) begin
            w = {1'b0, base + 8'(k)};
            fq[p].push_back(w);
            if (ex) exp_q.push_back({(k == int'(len) - 1), w});
        end
    endtask

    // Monitor: every output cycle is either the next expected word or idle
    always @(negedge clk) begin
        logic [9:0] e;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_word: got done=%0b ctl=%0b data=0x%02h required no word",
                         pkt_done, out_ctl, out_data);
            end else begin
                e = exp_q.pop_front();
                tests++;
                if ({pkt_done, out_ctl, out_data} !== e) begin
                    failed++;
                    $display("FAIL out_word: got done=%0b ctl=%0b data=0x%02h required done=%0b ctl=%0b data=0x%02h",
                             pkt_done, out_ctl, out_data, e[9], e[8], e[7:0]);
                end
            end
        end else begin
            tests++;
            if ({out_valid, pkt_done, out_ctl, out_data} !== 11'h100) begin
                failed++;
                $display("FAIL idle_pattern: got valid=%0b done=%0b ctl=%0b data=0x%02h required 0 0 1 0x00",
                         out_valid, pkt_done, out_ctl, out_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        fifo_empty = '1;
        fifo_dout  = '0;
        refresh();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_ctl",   {31'd0, out_ctl},   1);
        check("rst_out_data",  {24'd0, out_data},  0);
        check("rst_pkt_done",  {31'd0, pkt_done},  0);
        check("rst_hdr_err",   {31'd0, hdr_err},   0);
        check("rst_grant",     {28'd0, grant},     0);
        check("rst_fifo_rd",   {28'd0, fifo_rd},   0);

        // WR_RSP on port 1: header popped in the cycle it is offered
        body_pkt(1, 9'h104, 4, 8'hB0, 1'b1);
        refresh();
        #1;
        check("wr_pop_now", {28'd0, fifo_rd}, 32'h2);
        tick();
        check("wr_grant", {28'd0, grant}, 32'h2);
        check("wr_latency", {31'd0, out_valid}, 1);
        drain(20);
        check("wr_grant_clear", {28'd0, grant}, 0);

        // RD_RSP on port 2 with L=2: grant held for all six pops
        rd_pkt(2, 8'hA0, 8'h40, 8'd2, 8'hD0, 1'b1);
        refresh();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rd_grant_hold", {28'd0, grant}, 32'h4);
        end
        tick();
        check("rd_grant_end", {28'd0, grant}, 0);
        drain(10);

        // RD_RSP with L=0 ends on the length byte
        rd_pkt(2, 8'hA0, 8'h40, 8'd0, 8'h00, 1'b1);
        refresh();
        drain(10);
        check("rd_l0_grant", {28'd0, grant}, 0);

        // Every port holds MG_RSP from reset; port 0 has a second one queued
        do_reset();
        for (int p = 0; p < NP; p++) body_pkt(p, 9'h105, 5, 8'(p * 16), 1'b1);
        body_pkt(0, 9'h105, 5, 8'hE0, 1'b1);
        refresh();
        drain(60);

        // Port 3 underruns after two body bytes; port 1 waits its turn
        fq[3].push_back(9'h104); exp_q.push_back({1'b0, 9'h104});
        fq[3].push_back(9'h030); exp_q.push_back({1'b0, 9'h030});
        fq[3].push_back(9'h031); exp_q.push_back({1'b0, 9'h031});
        refresh();
        repeat (3) tick();
        exp_q.push_back({1'b0, 9'h032});
        exp_q.push_back({1'b1, 9'h033});
        body_pkt(1, 9'h104, 4, 8'h10, 1'b1);
        refresh();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", {31'd0, out_valid}, 0);
            check("stall_grant", {28'd0, grant}, 32'h8);
        end
        fq[3].push_back(9'h032);
        fq[3].push_back(9'h033);
        refresh();
        drain(30);

        // Invalid headers: opcode 7 on port 0, data word at head of port 2
        do_reset();
        fq[0].push_back(9'h107);
        body_pkt(1, 9'h104, 4, 8'h50, 1'b1);
        fq[2].push_back(9'h055);
        body_pkt(2, 9'h104, 4, 8'h60, 1'b1);
        refresh();
        tick();
        check("drop_hdr_err", {31'd0, hdr_err}, 1);
        check("drop_no_grant", {28'd0, grant}, 0);
        check("drop_popped", fq[0].size(), 0);
        tick();
        check("drop_next_port", {28'd0, grant}, 32'h2);
        drain(30);
        check("hdr_err_sticky", {31'd0, hdr_err}, 1);

        // Reset lands on the third body pop of an RD packet from port 0
        rd_pkt(0, 8'h11, 8'h22, 8'd3, 8'h70, 1'b0);
        exp_q.push_back({1'b0, 9'h103});
        exp_q.push_back({1'b0, 9'h011});
        exp_q.push_back({1'b0, 9'h022});
        refresh();
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("rst_no_pop_strobe", {28'd0, fifo_rd}, 0);
        tick();
        reset = 1'b0;
        check("rst_words_left", fq[0].size(), 4);
        fq[0].delete();
        refresh();
        check("mid_rst_valid", {31'd0, out_valid}, 0);
        check("mid_rst_ctl",   {31'd0, out_ctl},   1);
        check("mid_rst_done",  {31'd0, pkt_done},  0);
        check("mid_rst_err",   {31'd0, hdr_err},   0);
        check("mid_rst_grant", {28'd0, grant},     0);
        check("mid_rst_exp",   exp_q.size(),       0);
        body_pkt(0, 9'h105, 5, 8'h80, 1'b1);
        refresh();
        drain(20);

        // Longest RD packet: L=255 with no counter wrap
        rd_pkt(1, 8'h01, 8'h02, 8'd255, 8'h00, 1'b1);
        refresh();
        drain(300);
        check("long_grant_clear", {28'd0, grant}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/resp_sched.md
RESP_SCHED -- requirements
Module: resp_sched

Interface
REQ-001 SHALL have parameter NPORT, default 4: number of perm response FIFOs; all port-indexed vectors are NPORT bits wide, or NPORT entries of 9 bits.
REQ-002 SHALL have parameter WR_BODY, default 4: body bytes following a WR_RSP header.
REQ-003 SHALL have parameter MG_BODY, default 5: body bytes following an MG_RSP header.
REQ-004 SHALL have parameter RD_FIX, default 3: fixed body bytes following an RD_RSP header; the last fixed byte is the data length L.
REQ-005 SHALL use one clock; reset is synchronous and active-high, with ports named clk and reset.
REQ-006 SHALL have port clk, input, width 1: rising-edge clock.
REQ-007 SHALL have port reset, input, width 1: synchronous active-high reset.
REQ-008 SHALL have port fifo_empty, input, width NPORT: empty flag of each p2n FIFO.
REQ-009 SHALL have port fifo_dout, input, width 9*NPORT: first-word-fall-through head word {ctl,data} of each FIFO; port i occupies bits [9i+8:9i].
REQ-010 SHALL have port fifo_rd, output, width NPORT: pop strobe per FIFO, at most one bit high per cycle.
REQ-011 SHALL have port out_valid, output, width 1: out_ctl/out_data carry a packet word this cycle.
REQ-012 SHALL have port out_ctl, output, width 1: NOC ctl bit.
REQ-013 SHALL have port out_data, output, width 8: NOC data byte.
REQ-014 SHALL have port grant, output, width NPORT: one-hot owner of the current packet; all zero when idle.
REQ-015 SHALL have port pkt_done, output, width 1: one-cycle pulse with the last word of a packet on the output.
REQ-016 SHALL have port hdr_err, output, width 1: sticky flag for a discarded invalid header; cleared only by reset.

Function
REQ-017 SHALL define a header as a word with ctl=1 and data!=0; the opcode is data[2:0]: 3'b011 = RD_RSP, 3'b100 = WR_RSP, 3'b101 = MG_RSP.
REQ-018 SHALL implement a two-state FSM, IDLE and XFER, with a 9-bit remaining-word counter rem.
REQ-019 In IDLE, a port SHALL request when fifo_empty[i]=0; the winner SHALL be chosen round-robin, starting the search at (last winner + 1) mod NPORT.
REQ-020 In IDLE with a winner whose head is a valid header, the scheduler SHALL, in the same cycle: pop it, set grant, load rem (WR_BODY / MG_BODY / RD_FIX) and enter XFER.
REQ-021 In IDLE with a winner whose head is not a valid header (ctl=0, data=0 or undefined opcode), the scheduler SHALL pop and drop that word, set hdr_err, stay in IDLE and advance the round-robin pointer past that port.
REQ-022 In XFER, each cycle the granted FIFO is non-empty SHALL pop one word and decrement rem.
REQ-023 In XFER, a cycle in which the granted FIFO is empty (underrun) SHALL not pop, SHALL hold rem and grant, and SHALL produce out_valid=0.
REQ-024 For RD_RSP, when the last fixed body byte (rem=1 before decrement) is popped, the scheduler SHALL load rem with that byte's data value L; if L=0 the packet ends on that word.
REQ-025 When the final word is popped (rem reaches 0), the scheduler SHALL record the winner as last winner, clear grant and return to IDLE; a new arbitration MAY occur in the following cycle.
REQ-026 The grant SHALL not change while in XFER regardless of other ports' requests; there is no preemption.
REQ-027 Output SHALL be registered with 1-cycle latency: a word popped in cycle n appears on out_ctl/out_data with out_valid=1 in cycle n+1.
REQ-028 Dropped headers SHALL never reach the output.
REQ-029 pkt_done SHALL be high in cycle n+1 for the final pop in cycle n.
REQ-030 When out_valid=0, out_ctl SHALL be 1 and out_data SHALL be 0 (the NOC idle pattern).
REQ-031 rem arithmetic SHALL be 9-bit unsigned; L=255 SHALL give 255 data words with no wrap.
REQ-032 fifo_rd SHALL never be asserted for a port whose fifo_empty bit is 1.

Reset
REQ-033 On a reset edge the block SHALL enter IDLE with rem=0, grant=0, fifo_rd=0, out_valid=0, out_ctl=1, out_data=0, pkt_done=0 and hdr_err=0, and SHALL point round-robin so port 0 has highest priority.
REQ-034 Reset mid-packet SHALL abandon the packet, and SHALL not pop in the reset cycle.

Verification
REQ-035 Port 1 holds WR_RSP header 0x04 plus 4 bytes -> 5 consecutive pops; out words 0x104,b0..b3 in cycles n+1..n+5; pkt_done in cycle n+5.
REQ-036 Port 2 holds RD_RSP 0x03, then bytes 0xA0, 0x40, then 0x02, then d0, d1 -> 6 words out, grant=0100 throughout; L=0 variant -> 4 words out.
REQ-037 All 4 ports hold an MG_RSP from reset -> packets leave in port order 0,1,2,3 with no interleaving; then port 0 holds again -> port 0 is served after port 3.
REQ-038 Port 3 FIFO empties after 2 of 4 WR body bytes for 3 cycles -> out_valid=0 for 3 cycles, grant held, remaining 2 bytes follow, no other port served.
REQ-039 Port 0 head word ctl=1, data=0x07 -> dropped, hdr_err=1, no output word; port 1 served next.
REQ-040 Reset asserted on the 3rd body pop of an RD packet -> next cycle IDLE, all outputs at reset values; after reset a fresh header from port 0 is served normally.
